// File: rtl/lyr_out_serializer_if.sv
// Bus between the layer's parallel output bank, the serializer and the downstream consumer.
// The slave view belongs to the serializer; the master view drives it (upstream and consumer).
interface lyr_out_serializer_if #(
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned DATA_WIDTH  = 16
);
  localparam int unsigned IdxW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  // Parallel side
  logic [NUM_NEURONS*DATA_WIDTH-1:0] x_in;
  logic [NUM_NEURONS-1:0]            i_valid;
  logic                              i_ready;

  // Serial side
  logic [DATA_WIDTH-1:0] x_out;
  logic [IdxW-1:0]       o_idx;
  logic                  o_valid;
  logic                  o_ready;
  logic                  o_last;

  modport slave (
    input  x_in, i_valid, o_ready,
    output i_ready, x_out, o_idx, o_valid, o_last
  );

  modport master (
    output x_in, i_valid, o_ready,
    input  i_ready, x_out, o_idx, o_valid, o_last
  );
endinterface

// File: rtl/lyr_out_serializer.sv
// Snapshots a complete bank of neuron outputs on the rising edge of all-valid, optionally
// clamps negatives to zero, then streams the words one per handshake with neuron index.
module lyr_out_serializer #(
  parameter int unsigned NUM_NEURONS = 30,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          RELU_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  lyr_out_serializer_if.slave   bus,
  output logic                  overrun
);

  localparam int unsigned IdxW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  all_valid_q;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] word_q [NUM_NEURONS];

  logic all_valid;
  logic capture;
  logic last;

  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] w);
    if (RELU_EN && w[DATA_WIDTH-1]) return '0;
    return w;
  endfunction

  // Capture fires once per rising edge of all-valid, however long the set is held.
  always_comb begin
    all_valid = &bus.i_valid;
    capture   = all_valid & ~all_valid_q;
    last      = (state_q == StStream) && (idx_q == LastIdx);
  end

  // Next state, stream index and sticky overrun flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (bus.o_ready) begin
          if (last) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        // A set arriving while busy (even on the final handshake) is dropped.
        if (capture) overrun_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      all_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      all_valid_q <= all_valid;
      overrun_q   <= overrun_d;
    end
  end

  // Snapshot buffer; only written when a set is accepted, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StIdle) && capture) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        word_q[k] <= relu(bus.x_in[k*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  // Outputs depend on registers only.
  assign bus.i_ready = (state_q == StIdle);
  assign bus.o_valid = (state_q == StStream);
  assign bus.x_out   = (state_q == StStream) ? word_q[idx_q] : '0;
  assign bus.o_idx   = idx_q;
  assign bus.o_last  = last;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lyr_out_serializer.sv
// Bench for lyr_out_serializer: a queue-based model of the stream is compared against two
// instances (ReLU on and off) on every falling edge; directed tests add literal expectations.
module tb_lyr_out_serializer;

  localparam int unsigned N = 30;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]   words [N];
  logic [N*W-1:0] x_in;
  logic [N-1:0]   i_valid;
  logic           o_ready;
  logic           ovr1, ovr0;

  always_comb begin
    x_in = '0;
    for (int k = 0; k < N; k++) x_in[k*W +: W] = words[k];
  end

  lyr_out_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(W)) bus1 ();
  lyr_out_serializer_if #(.NUM_NEURONS(N), .DATA_WIDTH(W)) bus0 ();

  assign bus1.x_in    = x_in;
  assign bus1.i_valid = i_valid;
  assign bus1.o_ready = o_ready;
  assign bus0.x_in    = x_in;
  assign bus0.i_valid = i_valid;
  assign bus0.o_ready = o_ready;

  lyr_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W), .RELU_EN(1'b1)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1),
    .overrun (ovr1)
  );

  lyr_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W), .RELU_EN(1'b0)) u_dut_norelu (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus0),
    .overrun (ovr0)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] w);
    return w[W-1] ? '0 : w;
  endfunction

  // Model: the pending words of the current set, front = word on the bus.
  logic [W-1:0] raw_q [$];
  int           exp_idx  = 0;
  bit           prev_all = 1'b0;
  bit           exp_ovr  = 1'b0;
  bit           started  = 1'b0;
  bit           m_all, m_cap, m_busy;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      raw_q.delete();
      exp_idx  = 0;
      prev_all = 1'b0;
      exp_ovr  = 1'b0;
    end else begin
      m_all    = &i_valid;
      m_cap    = m_all && !prev_all;
      prev_all = m_all;
      m_busy   = raw_q.size() != 0;
      if (m_busy && o_ready) begin
        void'(raw_q.pop_front());
        exp_idx++;
        if (raw_q.size() == 0) exp_idx = 0;
      end
      if (m_cap) begin
        if (m_busy) exp_ovr = 1'b1;
        else begin
          for (int k = 0; k < N; k++) raw_q.push_back(words[k]);
          exp_idx = 0;
        end
      end
    end
  end

  // Accepted words as seen by the consumer.
  logic [W-1:0] log1 [$];
  logic [W-1:0] log0 [$];
  bit           lastlog [$];

  logic [31:0] e_valid, e_x1, e_x0, e_idx, e_last;

  always @(negedge clk) begin
    if (started) begin
      e_valid = 32'(raw_q.size() != 0);
      e_x1    = (raw_q.size() != 0) ? 32'(relu(raw_q[0])) : 32'd0;
      e_x0    = (raw_q.size() != 0) ? 32'(raw_q[0]) : 32'd0;
      e_idx   = (raw_q.size() != 0) ? 32'(exp_idx) : 32'd0;
      e_last  = 32'(raw_q.size() == 1);
      check("o_valid", 32'(bus1.o_valid), e_valid);
      check("o_valid_norelu", 32'(bus0.o_valid), e_valid);
      check("i_ready", 32'(bus1.i_ready), 32'(e_valid == 0));
      check("x_out", 32'(bus1.x_out), e_x1);
      check("x_out_norelu", 32'(bus0.x_out), e_x0);
      check("o_idx", 32'(bus1.o_idx), e_idx);
      check("o_last", 32'(bus1.o_last), e_last);
      check("overrun", 32'(ovr1), 32'(exp_ovr));
      check("overrun_norelu", 32'(ovr0), 32'(exp_ovr));
      if (bus1.o_valid && o_ready) begin
        log1.push_back(bus1.x_out);
        lastlog.push_back(bus1.o_last);
      end
      if (bus0.o_valid && o_ready) log0.push_back(bus0.x_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    i_valid = '1;
    tick();
    i_valid = '0;
  endtask

  task automatic clear_logs();
    log1.delete();
    log0.delete();
    lastlog.delete();
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (!bus1.i_ready && cycles < 300) begin
      tick();
      cycles++;
    end
    check({name, "_timeout"}, 32'(bus1.i_ready), 32'd1);
  endtask

  task automatic wait_idx(input string name, input int target);
    int c = 0;
    while (!(bus1.o_valid && int'(bus1.o_idx) == target) && c < 100) begin
      tick();
      c++;
    end
    check({name, "_reach"}, 32'(bus1.o_idx), 32'(target));
  endtask

  task automatic check_seq(input string name, input int base);
    int errs = 0;
    check({name, "_count"}, 32'(log1.size()), N);
    for (int k = 0; k < N; k++) begin
      if (k >= log1.size() || int'(log1[k]) != base + k) errs++;
    end
    check({name, "_order"}, 32'(errs), 32'd0);
  endtask

  task automatic set_ramp(input int base);
    for (int k = 0; k < N; k++) words[k] = W'(base + k);
  endtask

  int cyc;
  int n_last;

  initial begin
    i_valid = '0;
    o_ready = 1'b1;
    set_ramp(1);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_i_ready", 32'(bus1.i_ready), 32'd1);
    check("rst_o_valid", 32'(bus1.o_valid), 32'd0);
    check("rst_x_out", 32'(bus1.x_out), 32'd0);
    check("rst_o_idx", 32'(bus1.o_idx), 32'd0);
    check("rst_o_last", 32'(bus1.o_last), 32'd0);
    check("rst_overrun", 32'(ovr1), 32'd0);

    // Single set, o_ready high: words 1..30 on 30 consecutive cycles
    clear_logs();
    pulse();
    check("lat_o_valid", 32'(bus1.o_valid), 32'd1);
    check("lat_first_word", 32'(bus1.x_out), 32'd1);
    check("lat_first_idx", 32'(bus1.o_idx), 32'd0);
    wait_idle("single", cyc);
    check("single_cycles", 32'(cyc), 32'd30);
    check("single_idle_valid", 32'(bus1.o_valid), 32'd0);
    check_seq("single", 1);
    n_last = 0;
    foreach (lastlog[k]) if (lastlog[k]) n_last++;
    check("single_last_count", 32'(n_last), 32'd1);
    check("single_last_pos", 32'(lastlog.size() == N && lastlog[N-1]), 32'd1);

    // ReLU on vs off
    words[0] = 16'h8001;
    words[1] = 16'hFFFF;
    words[2] = 16'h7FFF;
    clear_logs();
    pulse();
    wait_idle("relu", cyc);
    check("relu_count", 32'(log1.size()), N);
    check("relu_w0", 32'(log1[0]), 32'h0000);
    check("relu_w1", 32'(log1[1]), 32'h0000);
    check("relu_w2", 32'(log1[2]), 32'h7FFF);
    check("norelu_w0", 32'(log0[0]), 32'h8001);
    check("norelu_w1", 32'(log0[1]), 32'hFFFF);
    check("norelu_w2", 32'(log0[2]), 32'h7FFF);
    set_ramp(1);

    // Backpressure: o_ready pattern 1,0,0 repeating
    clear_logs();
    pulse();
    cyc = 0;
    while (!bus1.i_ready && cyc < 300) begin
      o_ready = (cyc % 3 == 0);
      tick();
      cyc++;
    end
    o_ready = 1'b1;
    check("bp_timeout", 32'(bus1.i_ready), 32'd1);
    check_seq("bp", 1);

    // Held valid for 100 cycles: captured once
    clear_logs();
    i_valid = '1;
    repeat (100) tick();
    i_valid = '0;
    wait_idle("held", cyc);
    check_seq("held", 1);
    check("held_overrun", 32'(ovr1), 32'd0);

    // Partial valid never captures
    clear_logs();
    i_valid = '1;
    i_valid[7] = 1'b0;
    repeat (5) tick();
    check("partial_words", 32'(log1.size()), 32'd0);
    check("partial_o_valid", 32'(bus1.o_valid), 32'd0);
    i_valid = '0;
    tick();

    // Overrun: second set at word 10 is dropped
    clear_logs();
    pulse();
    wait_idx("ovr", 10);
    pulse();
    check("ovr_set", 32'(ovr1), 32'd1);
    wait_idle("ovr", cyc);
    check_seq("ovr", 1);
    repeat (40) tick();
    check("ovr_no_second", 32'(log1.size()), N);
    check("ovr_sticky", 32'(ovr1), 32'd1);

    // Reset mid-stream at word 15, then a fresh set
    set_ramp(100);
    pulse();
    wait_idx("rst_mid", 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_o_valid", 32'(bus1.o_valid), 32'd0);
    check("rst_mid_i_ready", 32'(bus1.i_ready), 32'd1);
    check("rst_mid_overrun", 32'(ovr1), 32'd0);
    clear_logs();
    pulse();
    check("after_rst_first", 32'(bus1.x_out), 32'd100);
    wait_idle("after_rst", cyc);
    check_seq("after_rst", 100);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lyr_out_serializer.md
# lyr_out_serializer

Downstream stage of the hidden layer: takes the layer's parallel bank of neuron outputs and per-neuron valids, snapshots a complete set, applies optional ReLU, and streams the words one per handshake to the next layer's serial input. It decouples the layer's parallel output from a single-word consumer, which may apply backpressure.

## Interface

Parameters:
- NUM_NEURONS, 30, number of neuron outputs in the bank
- DATA_WIDTH, 16, width of one neuron output word (signed two's complement)
- RELU_EN, 1, when 1 negative words are clamped to 0 at capture

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- x_in  in  NUM_NEURONS*DATA_WIDTH  neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_valid  in  NUM_NEURONS  per-neuron valid, bit k for neuron k
- i_ready  out  1  high when a new set can be captured (state IDLE)
- x_out  out  DATA_WIDTH  streamed word
- o_idx  out  $clog2(NUM_NEURONS)  neuron index of x_out
- o_valid  out  1  x_out/o_idx/o_last valid
- o_ready  in  1  consumer accepts the word this cycle
- o_last  out  1  high with the word for neuron NUM_NEURONS-1
- overrun  out  1  sticky: a complete set arrived while busy and was dropped

## Operation

- all_valid = AND of all i_valid bits; all_valid_d = all_valid registered each cycle (reset 0).
- Capture event = all_valid & ~all_valid_d (rising edge). A set held valid for many cycles is captured once.
- States: IDLE, STREAM.
- IDLE: i_ready=1, o_valid=0. On capture event: buf[k] <= relu(x_in word k) for all k, idx <= 0, go STREAM.
- STREAM: i_ready=0, o_valid=1, x_out=buf[idx], o_idx=idx, o_last=(idx==NUM_NEURONS-1).
  - o_valid & o_ready & ~o_last: idx <= idx+1.
  - o_valid & o_ready & o_last: go IDLE, idx <= 0.
  - ~o_ready: hold; x_out, o_idx, o_last stable.
- Capture event while in STREAM (including the cycle of the last handshake): set is dropped, overrun <= 1; buffer and stream unaffected. overrun clears only on rst.
- relu(w) = 0 if RELU_EN and w[DATA_WIDTH-1]==1, else w. No other arithmetic; width preserved.
- Partial valids (any i_valid bit low) never capture.

## Timing

- Reset (rst high at a clock edge): state IDLE, idx=0, o_valid=0, o_last=0, x_out=0, o_idx=0, overrun=0, all_valid_d=0, buf contents don't-care; i_ready=1 from the first cycle after reset.
- rst mid-stream aborts the stream immediately; no further words. If all_valid is high in the first cycle after reset it counts as a rising edge and captures.
- Latency: capture event sampled at edge T -> o_valid=1 with neuron 0 in cycle after T.
- With o_ready held high: words 0..NUM_NEURONS-1 on NUM_NEURONS consecutive cycles, o_last on the final one; o_valid=0 and i_ready=1 in the following cycle.
- Minimum period between accepted sets: NUM_NEURONS+1 cycles.
- x_out, o_idx, o_last, o_valid come from state/idx/buf registers only; no combinational path from o_ready or x_in to outputs except i_ready (from state).

## Test plan

- Reset then single set: x_in word k = k+1, all i_valid=1 for 1 cycle, o_ready=1 -> 30 words 1..30, o_idx 0..29, o_last only on 30, i_ready back to 1 after.
- ReLU: word 0 = 16'h8001, word 1 = 16'hFFFF, word 2 = 16'h7FFF, RELU_EN=1 -> streamed 0, 0, 16'h7FFF; with RELU_EN=0 -> 16'h8001, 16'hFFFF, 16'h7FFF.
- Backpressure: o_ready toggling 1,0,0,1,... -> every word appears exactly once in order, held stable while o_ready=0, total 30 handshakes.
- Held valid: all i_valid high for 100 cycles -> exactly one set streamed, overrun stays 0; i_valid bit 7 low with others high -> no capture.
- Overrun: second rising edge of all_valid at word 10 -> overrun=1, stream of first set completes unchanged, no second stream.
- Reset mid-stream at word 15 -> o_valid=0 next cycle, i_ready=1, overrun=0; new set afterwards streams from neuron 0.
